pipelined_add_sub: RTL and testbench

Parametrised, pipelined adder/subtractor for the datapath ALU. Splits a WIDTH-bit operation into STAGES equal chunks, adding one chunk per clock with the carry rippling stage to stage through registers. Uses a valid/ready handshake with bubble-collapsing backpressure, so throughput is one operation per clock. Also produces carry, signed-overflow and zero flags.

---
 rtl/pipelined_add_sub_if.sv | 16 +
 rtl/pipelined_add_sub.sv | 100 ++++++++++
 tb/tb_pipelined_add_sub.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_add_sub_if.sv
// pipelined_add_sub_if: operand/result valid-ready bus for pipelined_add_sub
interface pipelined_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid, in_ready, cin, sub;
    logic             out_valid, out_ready, cout, ovf, zero;
    logic [WIDTH-1:0] a, b, sum;
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit add/subtract split into STAGES chunk adders with a
// registered carry chain, bubble-collapsing valid/ready flow and carry/overflow/zero flags.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic                clk,
    input logic                rst,
    pipelined_add_sub_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] valid, carry;
    logic [STAGES:0]   ready;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic              a_msb [STAGES];
    logic              b_msb [STAGES];
    logic [WIDTH-1:0]  b_eff;
    logic              ovf_q, zero_q;

    assign b_eff         = bus.sub ? ~bus.b : bus.b;
    assign ready[STAGES] = bus.out_ready;
    assign bus.in_ready  = ready[0];
    assign bus.out_valid = valid[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.cout      = carry[STAGES-1];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in, b_in, s_in, s_nx, a_r, b_r, s_r;
        logic [CHUNK-1:0] part;
        logic             v_in, c_in, am_in, bm_in, c_nx;
        logic             v_r, c_r, am_r, bm_r;
        if (k == 0) begin : g_head
            assign v_in  = bus.in_valid;
            assign a_in  = bus.a;
            assign b_in  = b_eff;
            assign s_in  = '0;
            assign c_in  = bus.cin ^ bus.sub;
            assign am_in = bus.a[WIDTH-1];
            assign bm_in = b_eff[WIDTH-1];
        end else begin : g_body
            assign v_in  = valid[k-1];
            assign a_in  = a_q[k-1];
            assign b_in  = b_q[k-1];
            assign s_in  = sum_q[k-1];
            assign c_in  = carry[k-1];
            assign am_in = a_msb[k-1];
            assign bm_in = b_msb[k-1];
        end
        assign ready[k] = ~valid[k] | ready[k+1];
        // Operands shift down one chunk per stage so the current chunk is always the low bits
        always_comb begin
            {c_nx, part} = (CHUNK+1)'(a_in[CHUNK-1:0]) + (CHUNK+1)'(b_in[CHUNK-1:0]) + (CHUNK+1)'(c_in);
            s_nx = s_in | (WIDTH'(part) << (CHUNK * k));
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r  <= 1'b0;
                c_r  <= 1'b0;
                am_r <= 1'b0;
                bm_r <= 1'b0;
                a_r  <= '0;
                b_r  <= '0;
                s_r  <= '0;
            end else if (ready[k]) begin
                v_r <= v_in;
                if (v_in) begin
                    c_r  <= c_nx;
                    am_r <= am_in;
                    bm_r <= bm_in;
                    a_r  <= a_in >> CHUNK;
                    b_r  <= b_in >> CHUNK;
                    s_r  <= s_nx;
                end
            end
        end
        assign valid[k] = v_r;
        assign carry[k] = c_r;
        assign a_msb[k] = am_r;
        assign b_msb[k] = bm_r;
        assign a_q[k]   = a_r;
        assign b_q[k]   = b_r;
        assign sum_q[k] = s_r;
        if (k == STAGES - 1) begin : g_flags
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (ready[k] && v_in) begin
                    ovf_q  <= (am_in == bm_in) && (s_nx[WIDTH-1] != am_in);
                    zero_q <= s_nx == '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: scoreboard bench for pipelined_add_sub (32/4 main instance
// plus a parameter sweep of four further configurations).
module tb_pipelined_add_sub;
    typedef struct packed {logic [31:0] sum; logic cout; logic ovf; logic zero;} res_t;
    typedef struct packed {logic [31:0] a; logic [31:0] b; logic cin; logic sub;} op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    op_t  pend  [$];
    res_t exp_q [$];

    always #5 clk = ~clk;

    pipelined_add_sub_if #(.WIDTH(32)) bus ();
    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    function int sw_w(input int g);
        return g == 0 ? 8 : g == 1 ? 16 : g == 2 ? 64 : 32;
    endfunction
    function int sw_s(input int g);
        return g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 8 : 32;
    endfunction

    logic        sw_valid = 1'b0, sw_cin = 1'b0, sw_sub = 1'b0;
    logic [63:0] sw_a [4];
    logic [63:0] sw_b [4];
    logic [63:0] sw_sum [4];
    logic [3:0]  sw_ir, sw_ov, sw_cout, sw_ovf, sw_zero;

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W = sw_w(g);
        pipelined_add_sub_if #(.WIDTH(W)) sif ();
        pipelined_add_sub #(.WIDTH(W), .STAGES(sw_s(g))) dut (.clk(clk), .rst(rst), .bus(sif));
        assign sif.in_valid  = sw_valid;
        assign sif.a         = sw_a[g][W-1:0];
        assign sif.b         = sw_b[g][W-1:0];
        assign sif.cin       = sw_cin;
        assign sif.sub       = sw_sub;
        assign sif.out_ready = 1'b1;
        assign sw_ir[g]      = sif.in_ready;
        assign sw_ov[g]      = sif.out_valid;
        assign sw_sum[g]     = 64'(sif.sum);
        assign sw_cout[g]    = sif.cout;
        assign sw_ovf[g]     = sif.ovf;
        assign sw_zero[g]    = sif.zero;
    end

    // Reference: {ovf, zero, cout, sum} from a plain (w+1)-bit addition
    function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [64:0] mask, bp, full;
        mask = (65'd1 << w) - 65'd1;
        bp   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        full = ({1'b0, a} & mask) + bp + {64'd0, cin ^ sub};
        return {(a[w-1] == bp[w-1]) && (full[w-1] != a[w-1]), (full & mask) == 65'd0, full[w],
                full[63:0] & mask[63:0]};
    endfunction

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        op_t o;
        o = '{a: a, b: b, cin: cin, sub: sub};
        pend.push_back(o);
    endtask

    task automatic step(input logic ordy, output logic acc, output logic fired, output logic ov, output res_t got);
        logic [66:0] m;
        res_t        e;
        @(posedge clk);
        #1;
        bus.out_ready = ordy;
        bus.in_valid  = (pend.size() > 0);
        if (pend.size() > 0) {bus.a, bus.b, bus.cin, bus.sub} = pend[0];
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            m = model(32, {32'd0, pend[0].a}, {32'd0, pend[0].b}, pend[0].cin, pend[0].sub);
            e = '{sum: m[31:0], cout: m[64], ovf: m[66], zero: m[65]};
            exp_q.push_back(e);
            pend.delete(0);
        end
        ov    = bus.out_valid;
        fired = ov && bus.out_ready;
        got   = '{sum: bus.sum, cout: bus.cout, ovf: bus.ovf, zero: bus.zero};
    endtask

    task automatic test_reset();
        #12;
        n_tests += 2;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b %h c=%b o=%b z=%b want all 0", bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
        end
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        logic acc, f, ov;
        res_t got, e;
        int   as = -1, fo = -1;
        bit   done = 0;
        push_op(32'd2, 32'd6, 1'b0, 1'b0);
        for (int n = 0; n < 20 && !done; n++) begin
            step(1'b1, acc, f, ov, got);
            if (acc) as = n;
            if (ov && fo < 0) fo = n;
            if (f) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                done = 1;
                n_tests += 2;
                if (got !== 35'({32'd8, 3'b000})) begin
                    n_fail++;
                    $display("FAIL basic_add: got %h want %h", got, 35'({32'd8, 3'b000}));
                end
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL basic_model: got %h want %h", got, e);
                end
            end
        end
        n_tests++;
        if (!done || fo - as != 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 4 (done=%0d)", fo - as, done);
        end
    endtask

    task automatic test_ripple_sub();
        logic acc, f, ov;
        res_t got, e, w;
        res_t want [$];
        want.push_back('{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
        want.push_back('{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0});
        want.push_back('{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        want.push_back('{sum: 32'h0000_0001, cout: 1'b1, ovf: 1'b0, zero: 1'b0});
        want.push_back('{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0});
        push_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        push_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        push_op(32'd5, 32'd7, 1'b0, 1'b1);
        push_op(32'd7, 32'd5, 1'b1, 1'b1);
        push_op(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        for (int n = 0; n < 100 && want.size() > 0; n++) begin
            step(1'b1, acc, f, ov, got);
            if (f) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                w = want.pop_front();
                n_tests += 2;
                if (got !== w) begin
                    n_fail++;
                    $display("FAIL ripple_sub_const: got %h want %h", got, w);
                end
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL ripple_sub_model: got %h want %h", got, e);
                end
            end
        end
        if (want.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ripple_sub_timeout: got %0d results missing want 0", want.size());
        end
    endtask

    task automatic test_stream();
        logic [31:0] sa [8] = '{32'd2, 32'd16, 32'd124, 32'd1504, 32'd15031, 32'd65535, 32'd65535, 32'hFFFF_FFFF};
        logic [31:0] sb [8] = '{32'd6, 32'd23, 32'd215, 32'd4120, 32'd10154, 32'd1, 32'd65153, 32'd1};
        logic [32:0] want [8] = '{33'd8, 33'd39, 33'd339, 33'd5624, 33'd25185, 33'd65536, 33'd130688, 33'h1_0000_0000};
        logic acc, f, ov, stall;
        res_t got, prev, e;
        int   k = 0;
        stall = 1'b0;
        prev  = '0;
        for (int i = 0; i < 8; i++) push_op(sa[i], sb[i], 1'b0, 1'b0);
        for (int n = 0; n < 300 && k < 8; n++) begin
            step(1'($urandom_range(0, 1)), acc, f, ov, got);
            if (stall) begin
                n_tests++;
                if (!ov || got !== prev) begin
                    n_fail++;
                    $display("FAIL stream_hold: got v=%b %h want v=1 %h", ov, got, prev);
                end
            end
            stall = ov && !f;
            prev  = got;
            if (f) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_tests += 2;
                if ({got.cout, got.sum} !== want[k]) begin
                    n_fail++;
                    $display("FAIL stream_order[%0d]: got %h want %h", k, {got.cout, got.sum}, want[k]);
                end
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL stream_model[%0d]: got %h want %h", k, got, e);
                end
                k++;
            end
        end
        if (k < 8) begin
            n_tests++;
            n_fail++;
            $display("FAIL stream_timeout: got %0d results want 8", k);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, f, ov;
        res_t got, e;
        int   fa = -1, la = -1, na = 0, both = 0, k = 0;
        for (int i = 0; i < 8; i++) push_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int n = 0; n < 40 && k < 8; n++) begin
            step(1'b1, acc, f, ov, got);
            if (acc) begin
                if (fa < 0) fa = n;
                la = n;
                na++;
            end
            if (acc && f) both++;
            if (f) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL b2b_model[%0d]: got %h want %h", k, got, e);
                end
                k++;
            end
        end
        n_tests += 2;
        if (na != 8 || la - fa != 7) begin
            n_fail++;
            $display("FAIL b2b_throughput: got %0d accepts over %0d cycles want 8 over 8", na, la - fa + 1);
        end
        if (both != 4 || k != 8) begin
            n_fail++;
            $display("FAIL b2b_accept_emit: got overlap=%0d results=%0d want 4 8", both, k);
        end
    endtask

    task automatic test_stall();
        logic acc, f, ov;
        res_t got, e;
        int   na = 0, k = 0;
        push_op(32'd100, 32'd1, 1'b0, 1'b0);
        step(1'b0, acc, f, ov, got);
        na += int'(acc);
        step(1'b0, acc, f, ov, got);
        for (int i = 0; i < 5; i++) push_op(32'd1000 + 32'(i), 32'd3, 1'b1, 1'b1);
        for (int n = 0; n < 6; n++) begin
            step(1'b0, acc, f, ov, got);
            na += int'(acc);
        end
        n_tests += 2;
        if (na != 4) begin
            n_fail++;
            $display("FAIL stall_fill: got %0d accepts want 4", na);
        end
        if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_in_ready: got in_ready=%b out_valid=%b want 0 1", bus.in_ready, bus.out_valid);
        end
        for (int n = 0; n < 40 && k < 6; n++) begin
            step(1'b1, acc, f, ov, got);
            if (f) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL stall_drain[%0d]: got %h want %h", k, got, e);
                end
                k++;
            end
        end
        if (k < 6) begin
            n_tests++;
            n_fail++;
            $display("FAIL stall_timeout: got %0d results want 6", k);
        end
    endtask

    task automatic test_reset_midflight();
        logic acc, f, ov;
        res_t got;
        int   stale = 0;
        push_op(32'd2, 32'd6, 1'b0, 1'b0);
        push_op(32'd16, 32'd23, 1'b0, 1'b0);
        push_op(32'd124, 32'd215, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) step(1'b0, acc, f, ov, got);
        n_tests++;
        if (!ov || got.sum !== 32'd8) begin
            n_fail++;
            $display("FAIL midflight_pre: got v=%b sum=%h want v=1 sum=8", ov, got.sum);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero, bus.in_ready} !== 37'd1) begin
            n_fail++;
            $display("FAIL midflight_async: got v=%b %h c=%b o=%b z=%b rdy=%b want 0 0 0 0 0 1", bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero, bus.in_ready);
        end
        pend.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_in_ready: got %b want 1", bus.in_ready);
        end
        for (int n = 0; n < 10; n++) begin
            step(1'b1, acc, f, ov, got);
            stale += int'(ov);
        end
        n_tests++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL midflight_stale: got %0d stale outputs want 0", stale);
        end
    endtask

    task automatic test_sweep();
        logic [63:0] m, gs [4];
        logic [66:0] w;
        logic        gc [4], go [4], gz [4];
        int          lat [4];
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                m = (sw_w(g) == 64) ? '1 : (64'd1 << sw_w(g)) - 64'd1;
                sw_a[g] = c == 0 ? m : c == 1 ? m >> 1 : c == 2 ? 64'd5 : c == 3 ? 64'd7 : 64'd1 << (sw_w(g) - 1);
                sw_b[g] = c == 2 ? 64'd7 : c == 3 ? 64'd5 : 64'd1;
            end
            sw_cin   = (c == 3);
            sw_sub   = (c >= 2);
            sw_valid = 1'b1;
            @(negedge clk);
            n_tests++;
            if (sw_ir !== 4'hF) begin
                n_fail++;
                $display("FAIL sweep_accept[%0d]: got %b want 1111", c, sw_ir);
            end
            @(posedge clk);
            #1;
            sw_valid = 1'b0;
            for (int g = 0; g < 4; g++) lat[g] = -1;
            for (int t = 1; t <= 40; t++) begin
                @(negedge clk);
                for (int g = 0; g < 4; g++) begin
                    if (sw_ov[g] && lat[g] < 0) begin
                        lat[g] = t;
                        gs[g]  = sw_sum[g];
                        gc[g]  = sw_cout[g];
                        go[g]  = sw_ovf[g];
                        gz[g]  = sw_zero[g];
                    end
                end
            end
            for (int g = 0; g < 4; g++) begin
                w = model(sw_w(g), sw_a[g], sw_b[g], sw_cin, sw_sub);
                n_tests += 2;
                if (lat[g] != sw_s(g)) begin
                    n_fail++;
                    $display("FAIL sweep_latency W=%0d S=%0d case %0d: got %0d want %0d", sw_w(g), sw_s(g), c, lat[g], sw_s(g));
                end
                if (lat[g] < 0 || {go[g], gz[g], gc[g], gs[g]} !== w) begin
                    n_fail++;
                    $display("FAIL sweep_result W=%0d S=%0d case %0d: got %h want %h", sw_w(g), sw_s(g), c, {go[g], gz[g], gc[g], gs[g]}, w);
                end
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        for (int g = 0; g < 4; g++) begin
            sw_a[g] = '0;
            sw_b[g] = '0;
        end
        test_reset();
        test_basic();
        test_ripple_sub();
        test_stream();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
